// File: rtl/rotm_pipe_pkg.sv
// Shared request type and byte-mask helpers for the rotate-and-mask pipeline.
// Word and req_t describe the 32-bit request; wider instances reuse the helpers per byte lane.
package Pu_types;

    localparam int WORD_BYTES = 4;
    localparam int WORD_SHW   = 5;

    typedef logic [31:0] Word;

    typedef struct packed {
        Word                   w;
        Word                   ins;
        logic [WORD_SHW-1:0]   sh;
        logic                  bitmode;
        logic                  insert;
        logic [WORD_BYTES-1:0] mask;
    } req_t;

    function automatic logic [7:0] lane_mask(input logic en);
        return {8{en}};
    endfunction

    function automatic Word expand_mask(input logic [WORD_BYTES-1:0] mask);
        Word m;
        m = 32'h0000_0000;
        for (int i = 0; i < WORD_BYTES; i++) begin
            m[8*i +: 8] = lane_mask(mask[i]);
        end
        return m;
    endfunction

endpackage

// File: rtl/rotm_pipe_if.sv
// Request/response handshake bundle for rotm_pipe; the producer/consumer side is master,
// the pipeline is slave.
interface rotm_pipe_if #(
    parameter int BYTES = 4
);
    localparam int DW  = 8 * BYTES;
    localparam int SHW = $clog2(DW);

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_w;
    logic [DW-1:0]    in_ins;
    logic [SHW-1:0]   in_sh;
    logic             in_bitmode;
    logic             in_insert;
    logic [BYTES-1:0] in_mask;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_y;
    logic             busy;

    modport master (
        output in_valid, in_w, in_ins, in_sh, in_bitmode, in_insert, in_mask, out_ready,
        input  in_ready, out_valid, out_y, busy
    );

    modport slave (
        input  in_valid, in_w, in_ins, in_sh, in_bitmode, in_insert, in_mask, out_ready,
        output in_ready, out_valid, out_y, busy
    );

endinterface

// File: rtl/rotm_pipe_core.sv
// Combinational rotate and byte-mask merge. The rotate path (w/sh/bitmode -> rot) and the
// merge path (rw/mask/ins/insert -> y) are independent so the pipeline can place them in separate stages.
module rotm_core
    import Pu_types::*;
#(
    parameter int BYTES = 4
) (
    input  logic [8*BYTES-1:0]          w,
    input  logic [$clog2(8*BYTES)-1:0]  sh,
    input  logic                        bitmode,
    output logic [8*BYTES-1:0]          rot,
    input  logic [8*BYTES-1:0]          rw,
    input  logic [BYTES-1:0]            mask,
    input  logic [8*BYTES-1:0]          ins,
    input  logic                        insert,
    output logic [8*BYTES-1:0]          y
);

    localparam int DW  = 8 * BYTES;
    localparam int SHW = $clog2(DW);
    localparam int BYW = $clog2(BYTES);

    logic [SHW-1:0] amt_s;
    logic [SHW-1:0] amt_neg_s;
    logic [DW-1:0]  m_s;

    // Left rotate; byte mode scales the low BYW bits of sh to a bit count and drops the rest.
    always_comb begin
        amt_s = {SHW{1'b0}};
        if (bitmode) begin
            amt_s = sh;
        end else begin
            amt_s = {sh[BYW-1:0], 3'b000};
        end
        // amt_neg is DW-amt modulo DW, so a zero rotate ORs w with itself.
        amt_neg_s = {SHW{1'b0}} - amt_s;
        rot       = (w << amt_s) | (w >> amt_neg_s);
    end

    for (genvar i = 0; i < BYTES; i++) begin : g_lane
        assign m_s[8*i +: 8] = lane_mask(mask[i]);
    end

    // Merge the rotated word under the expanded mask, filling the rest with ins or zero.
    always_comb begin
        y = {DW{1'b0}};
        if (insert) begin
            y = (rw & m_s) | (ins & ~m_s);
        end else begin
            y = rw & m_s;
        end
    end

endmodule

// File: rtl/rotm_pipe.sv
// Two-stage rotate-and-mask pipeline: S1 holds the rotated word and merge controls,
// S2 holds the merged result that drives out_y/out_valid.
module rotm_pipe
    import Pu_types::*;
#(
    parameter int BYTES = 4
) (
    input  logic        clk,
    input  logic        reset,
    rotm_pipe_if.slave  bus
);

    localparam int DW  = 8 * BYTES;
    localparam int SHW = $clog2(DW);

    logic             s1_valid_q,  s1_valid_d;
    logic [DW-1:0]    s1_rot_q,    s1_rot_d;
    logic [DW-1:0]    s1_ins_q,    s1_ins_d;
    logic [BYTES-1:0] s1_mask_q,   s1_mask_d;
    logic             s1_insert_q, s1_insert_d;
    logic             s2_valid_q,  s2_valid_d;
    logic [DW-1:0]    s2_y_q,      s2_y_d;

    logic             s2_load_s;
    logic             in_ready_s;
    logic             accept_s;
    logic [DW-1:0]    core_rot_s;
    logic [DW-1:0]    core_y_s;
    logic [SHW-1:0]   in_sh_s;

    assign in_sh_s = bus.in_sh;

    rotm_core #(
        .BYTES (BYTES)
    ) u_core (
        .w       (bus.in_w),
        .sh      (in_sh_s),
        .bitmode (bus.in_bitmode),
        .rot     (core_rot_s),
        .rw      (s1_rot_q),
        .mask    (s1_mask_q),
        .ins     (s1_ins_q),
        .insert  (s1_insert_q),
        .y       (core_y_s)
    );

    // Handshake and next-state for both stages; in_ready never looks at in_valid.
    always_comb begin
        s2_load_s   = s1_valid_q & (~s2_valid_q | bus.out_ready);
        in_ready_s  = ~s1_valid_q | s2_load_s;
        accept_s    = bus.in_valid & in_ready_s;

        s1_valid_d  = s1_valid_q;
        s1_rot_d    = s1_rot_q;
        s1_ins_d    = s1_ins_q;
        s1_mask_d   = s1_mask_q;
        s1_insert_d = s1_insert_q;
        s2_valid_d  = s2_valid_q;
        s2_y_d      = s2_y_q;

        if (accept_s) begin
            s1_valid_d  = 1'b1;
            s1_rot_d    = core_rot_s;
            s1_ins_d    = bus.in_ins;
            s1_mask_d   = bus.in_mask;
            s1_insert_d = bus.in_insert;
        end else if (s2_load_s) begin
            s1_valid_d  = 1'b0;
        end else begin
            s1_valid_d  = s1_valid_q;
        end

        if (s2_load_s) begin
            s2_valid_d = 1'b1;
            s2_y_d     = core_y_s;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Stage valid bits and S2 result; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_y_q     <= {DW{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s2_y_q     <= s2_y_d;
        end
    end

    // S1 payload is qualified by s1_valid_q, so it carries no reset.
    always_ff @(posedge clk) begin
        s1_rot_q    <= s1_rot_d;
        s1_ins_q    <= s1_ins_d;
        s1_mask_q   <= s1_mask_d;
        s1_insert_q <= s1_insert_d;
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_y     = s2_y_q;
    assign bus.busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_rotm_pipe.sv
// Scoreboard bench for rotm_pipe: drivers push hand-computed results, negedge monitors pop and compare.
module tb_rotm_pipe;
    import Pu_types::*;

    typedef struct {
        logic [63:0] y;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t exp4_q[$];
    exp_t exp8_q[$];

    rotm_pipe_if #(.BYTES(4)) b4 ();
    rotm_pipe_if #(.BYTES(8)) b8 ();

    rotm_pipe #(.BYTES(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    rotm_pipe #(.BYTES(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_event(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %h, required none", name, act);
    endtask

    // Monitor for the 4-byte instance.
    always @(negedge clk) begin
        exp_t e;
        if (b4.out_valid === 1'b1 && b4.out_ready === 1'b1) begin
            if (exp4_q.size() == 0) begin
                fail_event("out4_spurious", 64'(b4.out_y));
            end else begin
                e = exp4_q.pop_front();
                check("out4_y", 64'(b4.out_y), e.y);
                if (e.lat) check("out4_latency", 64'(cyc - e.acc), 64'd2);
            end
        end
    end

    // Monitor for the 8-byte instance.
    always @(negedge clk) begin
        exp_t e;
        if (b8.out_valid === 1'b1 && b8.out_ready === 1'b1) begin
            if (exp8_q.size() == 0) begin
                fail_event("out8_spurious", b8.out_y);
            end else begin
                e = exp8_q.pop_front();
                check("out8_y", b8.out_y, e.y);
                if (e.lat) check("out8_latency", 64'(cyc - e.acc), 64'd2);
            end
        end
    end

    task automatic drive4(input req_t r);
        b4.in_w       = r.w;
        b4.in_ins     = r.ins;
        b4.in_sh      = r.sh;
        b4.in_bitmode = r.bitmode;
        b4.in_insert  = r.insert;
        b4.in_mask    = r.mask;
        b4.in_valid   = 1'b1;
    endtask

    task automatic send4(input req_t r, input Word y, input bit lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        drive4(r);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (b4.in_ready === 1'b1) begin
                e.y = {32'd0, y}; e.acc = cyc; e.lat = lat;
                exp4_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) fail_event("send4_timeout", 64'(r.w));
    endtask

    task automatic send8(input logic [63:0] w, input logic [63:0] ins, input logic [5:0] sh,
                         input logic bm, input logic insf, input logic [7:0] mask,
                         input logic [63:0] y, input bit lat);
        exp_t e;
        bit   done;
        done = 1'b0;
        b8.in_w = w; b8.in_ins = ins; b8.in_sh = sh;
        b8.in_bitmode = bm; b8.in_insert = insf; b8.in_mask = mask; b8.in_valid = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (b8.in_ready === 1'b1) begin
                e.y = y; e.acc = cyc; e.lat = lat;
                exp8_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) fail_event("send8_timeout", w);
        b8.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp4_q.size() == 0 && exp8_q.size() == 0) break;
        end
        check("drain4_empty", 64'(exp4_q.size()), 64'd0);
        check("drain8_empty", 64'(exp8_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    req_t vec[8];
    Word  vexp[8];
    req_t ra, rb, rc, rd, re, rf;

    initial begin
        vec[0] = '{w:32'hAABBCCDD, ins:32'h5A5A5A5A, sh:5'd1,  bitmode:1'b0, insert:1'b0, mask:4'hF}; vexp[0] = 32'hBBCCDDAA;
        vec[1] = '{w:32'h80000001, ins:32'h5A5A5A5A, sh:5'd1,  bitmode:1'b1, insert:1'b0, mask:4'hF}; vexp[1] = 32'h00000003;
        vec[2] = '{w:32'h80000001, ins:32'h5A5A5A5A, sh:5'd9,  bitmode:1'b0, insert:1'b0, mask:4'hF}; vexp[2] = 32'h00000180;
        vec[3] = '{w:32'h11223344, ins:32'hFFFFFFFF, sh:5'd0,  bitmode:1'b0, insert:1'b1, mask:4'h5}; vexp[3] = 32'hFF22FF44;
        vec[4] = '{w:32'h11223344, ins:32'hFFFFFFFF, sh:5'd0,  bitmode:1'b0, insert:1'b0, mask:4'h5}; vexp[4] = 32'h00220044;
        vec[5] = '{w:32'h00000001, ins:32'h5A5A5A5A, sh:5'd31, bitmode:1'b1, insert:1'b0, mask:4'hF}; vexp[5] = 32'h80000000;
        vec[6] = '{w:32'hAABBCCDD, ins:32'h5A5A5A5A, sh:5'd3,  bitmode:1'b0, insert:1'b0, mask:4'hF}; vexp[6] = 32'hDDAABBCC;
        vec[7] = '{w:32'h12345678, ins:32'hCAFEF00D, sh:5'd4,  bitmode:1'b1, insert:1'b1, mask:4'hA}; vexp[7] = 32'h23FE670D;
        ra = '{w:32'h01020304, ins:32'h0, sh:5'd2,  bitmode:1'b0, insert:1'b0, mask:4'hF};
        rb = '{w:32'h01020304, ins:32'h0, sh:5'd8,  bitmode:1'b1, insert:1'b0, mask:4'hF};
        rc = '{w:32'hDEADBEEF, ins:32'h0, sh:5'd0,  bitmode:1'b1, insert:1'b0, mask:4'h3};
        rd = '{w:32'hAABBCCDD, ins:32'h0, sh:5'd16, bitmode:1'b1, insert:1'b0, mask:4'hF};
        re = '{w:32'h11111111, ins:32'h0, sh:5'd0,  bitmode:1'b0, insert:1'b0, mask:4'hF};
        rf = '{w:32'h11223344, ins:32'h0, sh:5'd31, bitmode:1'b0, insert:1'b0, mask:4'hF};

        // Reset with a request presented: it must not be taken.
        reset = 1'b1;
        b4.out_ready = 1'b0;
        drive4(vec[0]);
        b8.in_valid = 1'b0; b8.in_w = 64'd0; b8.in_ins = 64'd0; b8.in_sh = 6'd0;
        b8.in_bitmode = 1'b0; b8.in_insert = 1'b0; b8.in_mask = 8'd0; b8.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(b4.in_ready),  64'd1);
        check("rst_out_valid", 64'(b4.out_valid), 64'd0);
        check("rst_busy",      64'(b4.busy),      64'd0);
        check("rst_out_y",     64'(b4.out_y),     64'd0);
        check("rst_out8_y",    b8.out_y,          64'd0);
        b4.in_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", 64'(b4.busy), 64'd0);

        // Directed vectors streamed back to back with latency checks.
        b4.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) send4(vec[i], vexp[i], 1'b1);
        b4.in_valid = 1'b0;
        drain();

        // Backpressure: two fill the pipe, the third waits.
        b4.out_ready = 1'b0;
        send4(ra, 32'h03040102, 1'b0);
        send4(rb, 32'h02030401, 1'b0);
        drive4(rc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_in_ready",  64'(b4.in_ready),  64'd0);
            check("bp_out_valid", 64'(b4.out_valid), 64'd1);
            check("bp_out_y",     64'(b4.out_y),     64'h03040102);
            check("bp_busy",      64'(b4.busy),      64'd1);
        end
        @(posedge clk); #1;
        b4.out_ready = 1'b1;
        send4(rc, 32'h0000BEEF, 1'b0);
        b4.in_valid = 1'b0;
        drain();

        // Reset with both stages full discards them.
        b4.out_ready = 1'b0;
        send4(rd, 32'hCCDDAABB, 1'b0);
        send4(re, 32'h11111111, 1'b0);
        b4.in_valid = 1'b0;
        check("full_busy", 64'(b4.busy), 64'd1);
        reset = 1'b1;
        exp4_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_out_valid", 64'(b4.out_valid), 64'd0);
        check("mid_rst_busy",      64'(b4.busy),      64'd0);
        check("mid_rst_in_ready",  64'(b4.in_ready),  64'd1);
        check("mid_rst_out_y",     64'(b4.out_y),     64'd0);
        b4.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_idle_busy", 64'(b4.busy), 64'd0);
        send4(rf, 32'h44112233, 1'b1);
        b4.in_valid = 1'b0;
        drain();

        // 8-byte instance.
        b8.out_ready = 1'b1;
        send8(64'h0102030405060708, 64'd0, 6'd7,  1'b0, 1'b0, 8'hFF, 64'h0801020304050607, 1'b1);
        send8(64'h0102030405060708, 64'd0, 6'd15, 1'b0, 1'b0, 8'hFF, 64'h0801020304050607, 1'b1);
        send8(64'h0000000000000001, 64'd0, 6'd63, 1'b1, 1'b0, 8'hFF, 64'h8000000000000000, 1'b1);
        send8(64'h0102030405060708, 64'hFFFFFFFFFFFFFFFF, 6'd0, 1'b0, 1'b1, 8'h0F, 64'hFFFFFFFF05060708, 1'b1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rotm_pipe.md
ROTM_PIPE -- requirements
Module: rotm_pipe

Interface
REQ-001 Parameter BYTES, default 4, SHALL set the data width DW = 8*BYTES; legal values are powers of two, 2..16.
REQ-002 Derived constant SHW = clog2(DW) SHALL be the shift-amount width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present on the in_* fields.
REQ-006 in_ready  output  1  block accepts the request this cycle.
REQ-007 in_w  input  DW  source word to rotate.
REQ-008 in_ins  input  DW  insert word, used only in insert mode.
REQ-009 in_sh  input  SHW  left-rotate amount.
REQ-010 in_bitmode  input  1  1 = bit granularity, 0 = byte granularity.
REQ-011 in_insert  input  1  1 = merge the insert word, 0 = zero the unmasked bytes.
REQ-012 in_mask  input  BYTES  byte mask; bit i covers byte i, bits [8i+7:8i].
REQ-013 out_valid  output  1  result present on out_y.
REQ-014 out_ready  input  1  consumer accepts the result.
REQ-015 out_y  output  DW  result word.
REQ-016 busy  output  1  high while either pipeline stage holds a request.

Function
REQ-017 Transfers SHALL occur on valid&ready at each port; the block SHALL never drop or duplicate a request.
REQ-018 Byte mode SHALL rotate in_w left by (in_sh mod BYTES) bytes and ignore the upper in_sh bits; with BYTES=4, sh=1 the result is {w[23:0], w[31:24]}.
REQ-019 Bit mode SHALL rotate in_w left by in_sh bits, 0..DW-1.
REQ-020 With M the byte-replicated in_mask, the result SHALL be rot&M in normal mode and (rot&M)|(in_ins&~M) in insert mode.
REQ-021 The pipeline SHALL have two registered stages: S1 latches the rotated word, ins, mask and insert flag; S2 latches the merged result, and out_y/out_valid come directly from S2.
REQ-022 Latency SHALL be 2 cycles: a request accepted in cycle n is presented with out_valid in cycle n+2 when there is no backpressure.
REQ-023 Throughput SHALL be 1 request per cycle while out_ready=1.
REQ-024 S2 SHALL load from S1 when S2 is empty or out_ready=1.
REQ-025 in_ready SHALL equal (S1 empty) OR (S2 will load this cycle), so a full pipeline holds 2 requests under backpressure.
REQ-026 A simultaneous accept into S1, S1-to-S2 advance and output transfer SHALL all take effect in the same cycle.
REQ-027 out_y SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 busy SHALL equal S1.valid OR S2.valid.
REQ-029 Output values in_ready and out_valid SHALL depend on registered state and out_ready only, never on in_valid.

Reset
REQ-030 While reset=1, both stage valid bits SHALL clear, giving out_valid=0, busy=0 and in_ready=1 from the next cycle on.
REQ-031 Reset SHALL clear S2 data so that out_y=0; S1 data registers need no reset.
REQ-032 Reset asserted mid-operation SHALL discard in-flight requests, and no out_valid SHALL appear for them afterwards.
REQ-033 A request presented during the reset cycle SHALL NOT be accepted.

Structure
REQ-034 The rotate and byte-mask expansion SHALL be a combinational sub-module rotm_core with parameter BYTES and ports w, sh, bitmode, mask, ins, insert, y; rotm_pipe instantiates it and splits its outputs across stages.
REQ-035 The package Pu_types SHALL hold the shared request struct (w, ins, sh, bitmode, insert, mask) and a function expanding the byte mask; Word SHALL remain the 32-bit type.

Verification
REQ-036 BYTES=4, byte mode, w=0xAABBCCDD, sh=1, mask=0xF, normal mode -> out_y=0xBBCCDDAA exactly 2 cycles after acceptance.
REQ-037 Bit mode, w=0x80000001, sh=1, mask=0xF -> 0x00000003; byte mode with sh=9 -> rotate by 1 byte, giving 0x00000180.
REQ-038 Insert mode, w=0x11223344, sh=0, mask=0x5, ins=0xFFFFFFFF -> 0xFF22FF44; with insert=0 -> 0x00220044.
REQ-039 Backpressure: 3 back-to-back requests with out_ready=0 -> 2 accepted, then in_ready=0; releasing out_ready drains the results in order with none lost.
REQ-040 Reset with S1 and S2 both full -> no out_valid after reset, busy=0, and the next request returns its result with latency 2.
REQ-041 BYTES=8 instance, byte mode, sh=7, w=0x0102030405060708, mask=0xFF -> 0x0801020304050607.
